// File: rtl/dmem_sram.sv
// Data-memory responder for the LSU dmem port: 1R1W word SRAM with byte-masked writes,
// pipelined reads with write-first forwarding, and a post-reset clear sequencer.
module dmem_sram #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                dmem_csb_write_i,
  input  logic [DATA_W/8-1:0] dmem_wmask_i,
  input  logic [ADDR_W-1:0]   dmem_waddr_i,
  input  logic [DATA_W-1:0]   dmem_din_i,
  input  logic                dmem_csb_read_i,
  input  logic [ADDR_W-1:0]   dmem_raddr_i,
  output logic [DATA_W-1:0]   dmem_dout_o,
  output logic                dmem_rvalid_o,
  output logic                ready_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_clr_we;
  logic                r_ready;
  logic                w_wr_fire;
  logic                w_rd_fire;
  logic [DATA_W-1:0]   w_rd_word;

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DATA_W-1:0]       r_pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pipe_vld;

  // Accesses are gated by the registered ready so nothing is accepted in the reset cycle.
  assign w_wr_fire = r_ready & ~dmem_csb_write_i & ~reset_i;
  assign w_rd_fire = r_ready & ~dmem_csb_read_i & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_READY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = RST_STATE;
      end
    endcase
  end

  // Array write port: clear sequencer or byte-masked user write.
  always_ff @(posedge clk_i) begin
    if (w_clr_we && !reset_i) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (dmem_wmask_i[b]) begin
          r_mem[dmem_waddr_i][8*b +: 8] <= dmem_din_i[8*b +: 8];
        end
      end
    end
  end

  // Write-first forwarding of a colliding write, applied only at the issue edge.
  always_comb begin
    w_rd_word = r_mem[dmem_raddr_i];
    if (w_wr_fire && (dmem_waddr_i == dmem_raddr_i)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (dmem_wmask_i[b]) begin
          w_rd_word[8*b +: 8] = dmem_din_i[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline; data stages load only behind a valid, so the last stage holds dout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pipe_data[k] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_fire;
      if (w_rd_fire) begin
        r_pipe_data[0] <= w_rd_word;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) begin
          r_pipe_data[k] <= r_pipe_data[k-1];
        end
      end
    end
  end

  assign dmem_dout_o   = r_pipe_data[READ_LATENCY-1];
  assign dmem_rvalid_o = r_pipe_vld[READ_LATENCY-1];
  assign ready_o       = r_ready;

endmodule

// File: tb/tb_dmem_sram.sv
// Scoreboard bench for dmem_sram: latency-1 and latency-3 instances share stimulus,
// plus a no-clear instance for the ready-after-reset path.
module tb_dmem_sram;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        csb_w;
  logic [3:0]  wmask;
  logic [7:0]  waddr;
  logic [31:0] din;
  logic        csb_r;
  logic [7:0]  raddr;

  logic [31:0] dout1, dout3, dout0;
  logic        rv1, rv3, rv0;
  logic        ready1, ready3, ready0;

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  sb_t         q1[$];
  sb_t         q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_sram #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask),
    .dmem_waddr_i(waddr), .dmem_din_i(din), .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
    .dmem_dout_o(dout1), .dmem_rvalid_o(rv1), .ready_o(ready1));

  dmem_sram #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u_dut3 (
    .clk_i(clk), .reset_i(reset_i), .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask),
    .dmem_waddr_i(waddr), .dmem_din_i(din), .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
    .dmem_dout_o(dout3), .dmem_rvalid_o(rv3), .ready_o(ready3));

  dmem_sram #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_dut0 (
    .clk_i(clk), .reset_i(reset_i), .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask),
    .dmem_waddr_i(waddr), .dmem_din_i(din), .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
    .dmem_dout_o(dout0), .dmem_rvalid_o(rv0), .ready_o(ready0));

  // Monitor for the latency-1 instance.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      if (rv1 === 1'b1) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL rd1_unexpected: rvalid with dout=%h at cyc %0d, required no rvalid", dout1, cyc);
        end else begin
          e = q1.pop_front();
          if (dout1 !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL rd1: dout=%h at cyc %0d, required %h at cyc %0d", dout1, cyc, e.data, e.due);
          end
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL rd1_missing: no rvalid at cyc %0d, required %h", cyc, e.data);
      end
    end
  end

  // Monitor for the latency-3 instance.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      if (rv3 === 1'b1) begin
        n_chk++;
        if (q3.size() == 0) begin
          n_fail++;
          $display("FAIL rd3_unexpected: rvalid with dout=%h at cyc %0d, required no rvalid", dout3, cyc);
        end else begin
          e = q3.pop_front();
          if (dout3 !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL rd3: dout=%h at cyc %0d, required %h at cyc %0d", dout3, cyc, e.data, e.due);
          end
        end
      end else if (q3.size() != 0 && q3[0].due <= cyc) begin
        e = q3.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL rd3_missing: no rvalid at cyc %0d, required %h", cyc, e.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb_w = 1'b1;
    csb_r = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
    csb_w = 1'b0; waddr = a; wmask = m; din = d;
    tick();
    csb_w = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input bit push3);
    csb_r = 1'b0; raddr = a;
    q1.push_back('{data: exp, due: cyc + 1});
    if (push3) q3.push_back('{data: exp, due: cyc + 3});
    tick();
    csb_r = 1'b1;
  endtask

  task automatic do_rw(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d,
                       input logic [31:0] exp);
    csb_w = 1'b0; waddr = a; wmask = m; din = d;
    csb_r = 1'b0; raddr = a;
    q1.push_back('{data: exp, due: cyc + 1});
    q3.push_back('{data: exp, due: cyc + 3});
    tick();
    idle();
  endtask

  // Applies whatever inputs the caller set together with a one-edge reset, then times the clear.
  task automatic reset_and_wait();
    int n;
    reset_i = 1'b1;
    tick();
    idle();
    reset_i = 1'b0;
    check("rst_dout1", dout1, 32'h0);
    check("rst_dout3", dout3, 32'h0);
    check("rst_dout0", dout0, 32'h0);
    check("rst_rvalid", 32'({rv0, rv1, rv3}), 32'h0);
    check("rst_ready1", 32'(ready1), 32'h0);
    check("rst_ready0", 32'(ready0), 32'h0);
    n = 0;
    while (ready1 !== 1'b1 && n < 600) begin
      if (n == 1) check("noclear_ready0", 32'(ready0), 32'h1);
      check("clear_ready3_low", 32'(ready3), 32'h0);
      n++;
      tick();
    end
    check("clear_cycles", 32'(n), 32'd256);
    check("clear_ready3_high", 32'(ready3), 32'h1);
  endtask

  initial begin
    reset_i = 1'b1;
    csb_w = 1'b1; csb_r = 1'b1;
    wmask = '0; waddr = '0; din = '0; raddr = '0;

    // Reset then clear; every word must read zero.
    reset_and_wait();
    mon_en = 1'b1;
    for (int a = 0; a < 256; a++) do_read(8'(a), 32'h0, 1'b1);
    repeat (4) tick();

    // Full-word write, read back, and hold after rvalid drops.
    do_write(8'd4, 4'hF, 32'h0000FFFF);
    tick(); tick();
    do_read(8'd4, 32'h0000FFFF, 1'b1);
    repeat (5) tick();
    check("hold_dout1", dout1, 32'h0000FFFF);
    check("hold_dout3", dout3, 32'h0000FFFF);
    check("hold_rvalid", 32'({rv1, rv3}), 32'h0);

    // Byte mask, then an all-zero mask no-op.
    do_write(8'd4, 4'b0100, 32'hAABBCCDD);
    do_read(8'd4, 32'h00BBFFFF, 1'b1);
    do_write(8'd4, 4'b0000, 32'hFFFFFFFF);
    do_read(8'd4, 32'h00BBFFFF, 1'b1);

    // Collision forwarding, and later writes do not touch an in-flight read.
    do_write(8'd9, 4'hF, 32'h11223344);
    do_rw(8'd9, 4'b0011, 32'hFFFF5566, 32'h11225566);
    do_read(8'd9, 32'h11225566, 1'b1);
    do_read(8'd9, 32'h11225566, 1'b1);
    do_write(8'd9, 4'hF, 32'hDEADBEEF);
    do_read(8'd9, 32'hDEADBEEF, 1'b1);

    // Top address and an untouched word.
    do_write(8'd255, 4'hF, 32'h12345678);
    do_read(8'd255, 32'h12345678, 1'b1);
    do_read(8'd0, 32'h0, 1'b1);

    // Back-to-back reads for the latency/pipelining timing.
    do_write(8'd1, 4'hF, 32'h0000000A);
    do_write(8'd2, 4'hF, 32'h0000000B);
    do_write(8'd3, 4'hF, 32'h0000000C);
    do_read(8'd1, 32'h0000000A, 1'b1);
    do_read(8'd2, 32'h0000000B, 1'b1);
    do_read(8'd3, 32'h0000000C, 1'b1);
    repeat (6) tick();

    // Reset with a latency-3 read in flight: only the latency-1 instance returns it.
    do_read(8'd9, 32'hDEADBEEF, 1'b0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("midrd_rvalid3", 32'(rv3), 32'h0);
    check("midrd_dout3", dout3, 32'h0);
    repeat (50) tick();
    do_write(8'd10, 4'hF, 32'hFFFFFFFF);
    repeat (49) tick();
    check("clear_no_rvalid", 32'({rv1, rv3}), 32'h0);
    csb_r = 1'b0; raddr = 8'd1;
    reset_and_wait();
    do_read(8'd10, 32'h0, 1'b1);
    do_read(8'd1, 32'h0, 1'b1);
    repeat (6) tick();

    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q3_drained", 32'(q3.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_sram.md
Name: dmem_sram

Overview:
- Data-memory responder at the far end of the LSU dmem port.
- 1R1W word-addressed SRAM model/controller with active-low chip selects, per-byte write mask, configurable read latency and same-cycle write-to-read forwarding.
- Holds a hardware clear sequencer that zeroes the array after reset, so simulations and the LSU start from known contents.

Parameters:
ADDR_W, 8, word address width; depth = 2**ADDR_W words
DATA_W, 32, word width; must be a multiple of 8
READ_LATENCY, 1, cycles from accepted read to dmem_dout_o valid; legal 1..3
CLEAR_ON_RESET, 1, 1 = run the clear sequencer after reset; 0 = skip the clear and go straight to ready

Ports:
clk_i  in  1  clock; all logic on the rising edge
reset_i  in  1  synchronous active-high reset
dmem_csb_write_i  in  1  write chip select, active low
dmem_wmask_i  in  DATA_W/8  byte write enables; bit b covers din[8b+7:8b]
dmem_waddr_i  in  ADDR_W  write word address
dmem_din_i  in  DATA_W  write data
dmem_csb_read_i  in  1  read chip select, active low
dmem_raddr_i  in  ADDR_W  read word address
dmem_dout_o  out  DATA_W  read data
dmem_rvalid_o  out  1  one-cycle pulse marking dmem_dout_o valid
ready_o  out  1  high when accesses are accepted

Behaviour:
- Reset (reset_i=1 at an edge):
  - dmem_dout_o=0, dmem_rvalid_o=0, ready_o=0.
  - Read pipeline valid bits cleared, clear counter cleared.
  - FSM goes to CLEAR, or to READY if CLEAR_ON_RESET=0.
  - A reset asserted mid-CLEAR or mid-read restarts the sequence; in-flight reads are dropped and produce no rvalid.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. On the cycle cnt reaches 2**ADDR_W-1, go to READY on the next edge; the full clear takes 2**ADDR_W cycles.
  - READY: ready_o=1. There is no exit except reset.
- In CLEAR, ready_o=0 and both chip selects are ignored: no write and no read pulse.
- Write (READY, csb_write=0):
  - At the edge, byte b of mem[waddr] is updated iff wmask[b]=1; other bytes keep their value.
  - wmask=0 with csb low is a legal no-op.
- Read (READY, csb_read=0):
  - The request is captured at edge T.
  - dmem_dout_o is updated and dmem_rvalid_o=1 after edge T+READY_LATENCY-1, visible during cycle T+READ_LATENCY.
  - Example for READ_LATENCY=1: the value is registered at T and visible the cycle after T.
  - Fully pipelined: one read per cycle, and a back-to-back stream yields a back-to-back rvalid stream.
- Read data hold: dmem_dout_o holds its last value when no rvalid is issued; it is never forced to 0 except by reset.
- Collision (csb_read=0 and csb_write=0 at the same edge, raddr==waddr): write-first.
  - Returned byte b = din byte b if wmask[b]=1, else the old mem byte.
  - Forwarding applies only at the issue edge. Later writes to the same address do not alter a read already in the pipeline.
- Address wrap: addresses are ADDR_W bits and there is no out-of-range case.
- Unused bits: none; all inputs are fully decoded.

Test Plan:
1. Reset then clear:
   - Stimulus: reset 1 cycle, CLEAR_ON_RESET=1, then read every address.
   - Required: ready_o low for exactly 256 cycles, then high; every word reads 0x00000000.
2. Full-word write then read:
   - Stimulus: write waddr=4, wmask=4'hF, din=0x0000FFFF; two idle cycles; read raddr=4.
   - Required: rvalid one cycle after the read edge with dout=0x0000FFFF; dout holds that value after rvalid drops.
3. Byte mask:
   - Stimulus: mem[4]=0x0000FFFF; write wmask=4'b0100, din=0xAABBCCDD; read addr 4.
   - Required: dout=0x00BBFFFF.
4. Collision forwarding:
   - Stimulus: mem[9]=0x11223344; at one edge, read 9 and write 9 with wmask=4'b0011, din=0xFFFF5566.
   - Required: dout=0x11225566, and a following read of 9 also returns 0x11225566.
5. Latency and pipelining:
   - Stimulus: READ_LATENCY=3; reads of addresses 1, 2, 3 on consecutive edges, preloaded with 0xA, 0xB, 0xC.
   - Required: rvalid high on 3 consecutive cycles starting 3 cycles after the first request, with data 0xA, 0xB, 0xC.
6. Reset mid-operation:
   - Stimulus: assert reset 1 cycle during CLEAR at cnt=100 with a pending READ_LATENCY=3 read; separately, drive a write during CLEAR.
   - Required: no rvalid; clear restarts and ready_o returns after 256 cycles; the write issued during CLEAR leaves the target word at 0.
